// File: rtl/writeback_ctrl_pkg.sv
// Shared definitions for the coffee-cpu writeback stage: opcodes, write
// conditions, controller states, cpuStatus codes and special register indices.
package cpu_pkg;

    // Opcodes
    localparam logic [4:0] OPC_NOP   = 5'h00;
    localparam logic [4:0] OPC_LOAD  = 5'h01;
    localparam logic [4:0] OPC_STORE = 5'h02;
    localparam logic [4:0] OPC_ADD   = 5'h03;
    localparam logic [4:0] OPC_SUB   = 5'h04;
    localparam logic [4:0] OPC_AND   = 5'h05;
    localparam logic [4:0] OPC_OR    = 5'h06;
    localparam logic [4:0] OPC_XOR   = 5'h07;
    localparam logic [4:0] OPC_HALT  = 5'h1F;

    // Write conditions, evaluated against committed status flags
    typedef enum logic [2:0] {
        COND_NEVER   = 3'd0,
        COND_ALWAYS  = 3'd1,
        COND_ZERO    = 3'd2,
        COND_NOTZERO = 3'd3,
        COND_GE      = 3'd4,
        COND_LT      = 3'd5,
        COND_GT      = 3'd6,
        COND_LE      = 3'd7
    } cond_e;

    // Writeback controller states
    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLoadWait = 2'd1,
        StFlush    = 2'd2,
        StHalt     = 2'd3
    } wb_state_e;

    // cpuStatus encodings
    localparam logic [7:0] CPU_ST_RUN      = 8'h01;
    localparam logic [7:0] CPU_ST_RESET    = 8'h02;
    localparam logic [7:0] CPU_ST_HALT     = 8'h04;
    localparam logic [7:0] CPU_ST_LOADWAIT = 8'h08;

    // Flag bit positions in aluStatus / status
    localparam int unsigned STATUS_ZERO_BIT = 0;
    localparam int unsigned STATUS_GE_BIT   = 2;

    // The two highest register indices are the PC and the overflow register
    function automatic int unsigned pc_index(input int unsigned reg_aw);
        return (32'd1 << reg_aw) - 32'd2;
    endfunction

    function automatic int unsigned ovf_index(input int unsigned reg_aw);
        return (32'd1 << reg_aw) - 32'd1;
    endfunction

endpackage

// File: rtl/writeback_ctrl_if.sv
// Writeback-stage bus: retiring instruction, load data, Execute operand
// addresses, Decode read ports and pipeline-control outputs.
interface writeback_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 12,
    parameter int unsigned REG_AW = 4
);
    logic              wbValid;
    logic [4:0]        wbOpc;
    logic [REG_AW-1:0] wbRc;
    logic [2:0]        wbCond;
    logic              wbCmp;
    logic [DATA_W-1:0] aluOut;
    logic [7:0]        aluStatus;
    logic [DATA_W-1:0] dataIn;
    logic              dataValid;
    logic [REG_AW-1:0] exRa;
    logic [REG_AW-1:0] exRb;
    logic              exImb;
    logic [REG_AW-1:0] rdAddrA;
    logic [REG_AW-1:0] rdAddrB;
    logic [DATA_W-1:0] rdDataA;
    logic [DATA_W-1:0] rdDataB;
    logic [PC_W-1:0]   pc;
    logic              stall;
    logic              flushRst;
    logic [DATA_W-1:0] fwdData;
    logic              fwdEnA;
    logic              fwdEnB;
    logic [7:0]        status;
    logic [7:0]        cpuStatus;

    // Pipeline side: drives the retiring instruction, observes control
    modport master (
        output wbValid, wbOpc, wbRc, wbCond, wbCmp, aluOut, aluStatus,
        output dataIn, dataValid, exRa, exRb, exImb, rdAddrA, rdAddrB,
        input  rdDataA, rdDataB, pc, stall, flushRst, fwdData, fwdEnA, fwdEnB,
        input  status, cpuStatus
    );

    // Writeback controller side
    modport slave (
        input  wbValid, wbOpc, wbRc, wbCond, wbCmp, aluOut, aluStatus,
        input  dataIn, dataValid, exRa, exRb, exImb, rdAddrA, rdAddrB,
        output rdDataA, rdDataB, pc, stall, flushRst, fwdData, fwdEnA, fwdEnB,
        output status, cpuStatus
    );
endinterface

// File: rtl/writeback_ctrl_cond_eval.sv
// Combinational write-condition evaluator: condition code plus zero/ge flags
// to a single enable. Kept standalone so branch prediction can reuse it.
module wb_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic       i_zero,
    input  logic       i_ge,
    output logic       o_en
);

    // Decode the condition against the flags
    always_comb begin
        o_en = 1'b0;
        unique case (cond_e'(i_cond))
            COND_NEVER:   o_en = 1'b0;
            COND_ALWAYS:  o_en = 1'b1;
            COND_ZERO:    o_en = i_zero;
            COND_NOTZERO: o_en = !i_zero;
            COND_GE:      o_en = i_ge;
            COND_LT:      o_en = !i_ge;
            COND_GT:      o_en = i_ge && !i_zero;
            COND_LE:      o_en = !i_ge || i_zero;
            default:      o_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/writeback_ctrl.sv
// Writeback, register file and pipeline control for the coffee-cpu core.
// Retires the instruction leaving Execute, commits it to a general register,
// the PC or the overflow register, forwards it to Execute, and sequences
// load-wait stalls, post-branch flushes and HALT.
module writeback_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PC_W         = 12,
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            nRst,
    writeback_ctrl_if.slave bus
);

    localparam int unsigned       NUM_REGS   = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] PC_IDX     = REG_AW'(pc_index(REG_AW));
    localparam logic [REG_AW-1:0] OVF_IDX    = REG_AW'(ovf_index(REG_AW));
    localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    wb_state_e         r_state;
    wb_state_e         w_state_next;
    logic              r_rst_cyc;
    logic [3:0]        r_flush_cnt;
    logic [3:0]        w_flush_cnt_next;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_overflow;
    logic [7:0]        r_status;
    logic [DATA_W-1:0] r_fwd_data;
    logic              r_fwd_en_a;
    logic              r_fwd_en_b;

    logic              w_active;
    logic              w_is_load;
    logic              w_is_halt;
    logic              w_is_nop;
    logic              w_load_wait;
    logic              w_stall;
    logic              w_retire;
    logic              w_cond_en;
    logic              w_commit;
    logic              w_to_pc;
    logic              w_to_ovf;
    logic [DATA_W-1:0] w_value;

    wb_cond_eval u_cond_eval (
        .i_cond (bus.wbCond),
        .i_zero (r_status[STATUS_ZERO_BIT]),
        .i_ge   (r_status[STATUS_GE_BIT]),
        .o_en   (w_cond_en)
    );

    // Retire/commit qualification; the reset-release cycle behaves like a flush
    always_comb begin
        w_active    = !r_rst_cyc && ((r_state == StRun) || (r_state == StLoadWait));
        w_is_load   = (bus.wbOpc == OPC_LOAD);
        w_is_halt   = (bus.wbOpc == OPC_HALT);
        w_is_nop    = (bus.wbOpc == OPC_NOP);
        w_load_wait = w_active && bus.wbValid && w_is_load && !bus.dataValid;
        w_stall     = (r_state == StHalt) || w_load_wait;
        w_retire    = w_active && bus.wbValid && !w_stall;
        w_commit    = w_retire && (w_is_load || (!w_is_nop && !w_is_halt && w_cond_en));
        w_value     = w_is_load ? bus.dataIn : bus.aluOut;
        w_to_pc     = w_commit && (bus.wbRc == PC_IDX);
        w_to_ovf    = w_commit && (bus.wbRc == OVF_IDX);
    end

    // Next-state and flush counter
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        unique case (r_state)
            StRun, StLoadWait: begin
                if (w_load_wait) begin
                    w_state_next = StLoadWait;
                end else if (w_retire && w_is_halt) begin
                    w_state_next = StHalt;
                end else if (w_to_pc) begin
                    w_state_next     = StFlush;
                    w_flush_cnt_next = FLUSH_LOAD;
                end else begin
                    w_state_next = StRun;
                end
            end
            StFlush: begin
                if (r_flush_cnt == 4'd0) begin
                    w_state_next = StRun;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 4'd1;
                end
            end
            StHalt: w_state_next = StHalt;
            default: w_state_next = StRun;
        endcase
    end

    // State register and reset-release marker
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= StRun;
            r_flush_cnt <= 4'd0;
            r_rst_cyc   <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_rst_cyc   <= 1'b0;
        end
    end

    // Architectural state: pc, register file, overflow and status
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_pc       <= '0;
            r_overflow <= '0;
            r_status   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_to_pc) begin
                r_pc <= w_value[PC_W-1:0];
            end else if (w_retire && !w_is_halt) begin
                r_pc <= r_pc + PC_W'(1);
            end
            if (w_commit && !w_to_pc && !w_to_ovf) begin
                r_regs[bus.wbRc] <= w_value;
            end
            if (w_to_ovf) begin
                r_overflow <= w_value;
            end
            if (w_retire && !w_is_load && bus.wbCmp) begin
                r_status <= bus.aluStatus;
            end
        end
    end

    // Execute forwarding; holds while stalled since nothing retires then
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_fwd_data <= '0;
            r_fwd_en_a <= 1'b0;
            r_fwd_en_b <= 1'b0;
        end else if (w_commit && !w_to_pc) begin
            r_fwd_data <= w_value;
            r_fwd_en_a <= (bus.exRa == bus.wbRc);
            r_fwd_en_b <= !bus.exImb && (bus.exRb == bus.wbRc);
        end else if (w_retire) begin
            r_fwd_en_a <= 1'b0;
            r_fwd_en_b <= 1'b0;
        end
    end

    // Decode read ports, no bypass from the commit in flight
    always_comb begin
        bus.rdDataA = r_regs[bus.rdAddrA];
        if (bus.rdAddrA == PC_IDX) begin
            bus.rdDataA = DATA_W'(r_pc);
        end else if (bus.rdAddrA == OVF_IDX) begin
            bus.rdDataA = r_overflow;
        end
        bus.rdDataB = r_regs[bus.rdAddrB];
        if (bus.rdAddrB == PC_IDX) begin
            bus.rdDataB = DATA_W'(r_pc);
        end else if (bus.rdAddrB == OVF_IDX) begin
            bus.rdDataB = r_overflow;
        end
    end

    // Control and status outputs
    always_comb begin
        bus.pc       = r_pc;
        bus.stall    = w_stall;
        bus.flushRst = r_rst_cyc || (r_state == StFlush);
        bus.fwdData  = r_fwd_data;
        bus.fwdEnA   = r_fwd_en_a;
        bus.fwdEnB   = r_fwd_en_b;
        bus.status   = r_status;
        bus.cpuStatus = CPU_ST_RUN;
        if (r_rst_cyc) begin
            bus.cpuStatus = CPU_ST_RESET;
        end else if (r_state == StLoadWait) begin
            bus.cpuStatus = CPU_ST_LOADWAIT;
        end else if (r_state == StHalt) begin
            bus.cpuStatus = CPU_ST_HALT;
        end
    end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl with FLUSH_CYCLES=3, REG_AW=4
// (PC index 14, overflow index 15).
module tb_writeback_ctrl;

    logic clk;
    logic nRst;
    int   checks;
    int   errors;

    writeback_ctrl_if #(.DATA_W(32), .PC_W(12), .REG_AW(4)) bus ();

    writeback_ctrl #(
        .DATA_W       (32),
        .PC_W         (12),
        .REG_AW       (4),
        .FLUSH_CYCLES (3)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] opc, input logic [3:0] rc, input logic [2:0] cond,
                         input logic cmp, input logic [31:0] alu, input logic [7:0] ast);
        bus.wbValid   = 1'b1;
        bus.wbOpc     = opc;
        bus.wbRc      = rc;
        bus.wbCond    = cond;
        bus.wbCmp     = cmp;
        bus.aluOut    = alu;
        bus.aluStatus = ast;
    endtask

    task automatic ex_ops(input logic [3:0] ra, input logic [3:0] rb, input logic imb);
        bus.exRa  = ra;
        bus.exRb  = rb;
        bus.exImb = imb;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nRst   = 1'b0;
        bus.wbValid   = 1'b0;
        bus.wbOpc     = 5'h00;
        bus.wbRc      = 4'd0;
        bus.wbCond    = 3'd0;
        bus.wbCmp     = 1'b0;
        bus.aluOut    = 32'h0;
        bus.aluStatus = 8'h00;
        bus.dataIn    = 32'h0;
        bus.dataValid = 1'b0;
        ex_ops(4'd0, 4'd0, 1'b1);
        bus.rdAddrA   = 4'd0;
        bus.rdAddrB   = 4'd14;

        // Reset held, then released mid-cycle
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_cpustatus", 32'(bus.cpuStatus), 32'h02);
        check("rst_flush", 32'(bus.flushRst), 32'h1);
        check("rst_rdA", bus.rdDataA, 32'h0);
        check("rst_rdB_pc", bus.rdDataB, 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        #2 nRst = 1'b1;
        #1;
        check("rel_cpustatus", 32'(bus.cpuStatus), 32'h02);
        check("rel_flush", 32'(bus.flushRst), 32'h1);
        tick();
        check("run_cpustatus", 32'(bus.cpuStatus), 32'h01);
        check("run_flush", 32'(bus.flushRst), 32'h0);

        // ADD r3 = 0x1234, both Execute operands read r3
        issue(5'h03, 4'd3, 3'd1, 1'b0, 32'h1234, 8'h00);
        ex_ops(4'd3, 4'd3, 1'b0);
        #1;
        check("add_stall", 32'(bus.stall), 32'h0);
        tick();
        bus.wbValid = 1'b0;
        check("add_fwdA", 32'(bus.fwdEnA), 32'h1);
        check("add_fwdB", 32'(bus.fwdEnB), 32'h1);
        check("add_fwdData", bus.fwdData, 32'h1234);
        check("add_pc", 32'(bus.pc), 32'h1);
        bus.rdAddrA = 4'd3;
        #1;
        check("add_r3", bus.rdDataA, 32'h1234);
        check("add_rd_pc", bus.rdDataB, 32'h1);

        // Compare sets ge, then GT commits r2 = 0x55
        issue(5'h03, 4'd7, 3'd0, 1'b1, 32'h0, 8'h04);
        ex_ops(4'd0, 4'd0, 1'b1);
        tick();
        check("cmp_status", 32'(bus.status), 32'h04);
        check("cmp_fwd_clr", 32'(bus.fwdEnA), 32'h0);
        check("cmp_pc", 32'(bus.pc), 32'h2);
        issue(5'h03, 4'd2, 3'd6, 1'b0, 32'h55, 8'h00);
        ex_ops(4'd2, 4'd0, 1'b1);
        tick();
        bus.wbValid = 1'b0;
        check("gt_fwdA", 32'(bus.fwdEnA), 32'h1);
        check("gt_fwdB_imm", 32'(bus.fwdEnB), 32'h0);
        check("gt_fwdData", bus.fwdData, 32'h55);
        check("gt_pc", 32'(bus.pc), 32'h3);
        bus.rdAddrA = 4'd2;
        #1;
        check("gt_r2", bus.rdDataA, 32'h55);

        // Status zero+ge: GT false (no commit, pc still advances), LE true
        issue(5'h03, 4'd7, 3'd0, 1'b1, 32'h0, 8'h05);
        tick();
        check("cmp2_status", 32'(bus.status), 32'h05);
        check("cmp2_pc", 32'(bus.pc), 32'h4);
        issue(5'h03, 4'd2, 3'd6, 1'b0, 32'h66, 8'h00);
        ex_ops(4'd2, 4'd2, 1'b0);
        tick();
        bus.wbValid = 1'b0;
        check("gtf_pc", 32'(bus.pc), 32'h5);
        check("gtf_fwdA", 32'(bus.fwdEnA), 32'h0);
        check("gtf_r2", bus.rdDataA, 32'h55);
        issue(5'h03, 4'd4, 3'd7, 1'b0, 32'h77, 8'h00);
        ex_ops(4'd4, 4'd0, 1'b1);
        tick();
        bus.wbValid = 1'b0;
        check("le_pc", 32'(bus.pc), 32'h6);
        check("le_fwdA", 32'(bus.fwdEnA), 32'h1);
        bus.rdAddrA = 4'd4;
        #1;
        check("le_r4", bus.rdDataA, 32'h77);

        // LOAD r5 with data late by three cycles
        issue(5'h01, 4'd5, 3'd0, 1'b0, 32'h0, 8'h00);
        bus.dataValid = 1'b0;
        ex_ops(4'd5, 4'd0, 1'b1);
        #1;
        check("ld_stall1", 32'(bus.stall), 32'h1);
        tick();
        check("ld_stall2", 32'(bus.stall), 32'h1);
        check("ld_cpustatus", 32'(bus.cpuStatus), 32'h08);
        check("ld_pc_hold", 32'(bus.pc), 32'h6);
        check("ld_fwd_hold", bus.fwdData, 32'h77);
        check("ld_fwdA_hold", 32'(bus.fwdEnA), 32'h1);
        tick();
        check("ld_stall3", 32'(bus.stall), 32'h1);
        tick();
        bus.dataValid = 1'b1;
        bus.dataIn    = 32'hCAFE;
        #1;
        check("ld_stall_drop", 32'(bus.stall), 32'h0);
        tick();
        bus.wbValid   = 1'b0;
        bus.dataValid = 1'b0;
        check("ld_run", 32'(bus.cpuStatus), 32'h01);
        check("ld_pc", 32'(bus.pc), 32'h7);
        check("ld_fwdData", bus.fwdData, 32'hCAFE);
        bus.rdAddrA = 4'd5;
        #1;
        check("ld_r5", bus.rdDataA, 32'hCAFE);

        // Overflow register write
        issue(5'h03, 4'd15, 3'd1, 1'b0, 32'hDEAD, 8'h00);
        ex_ops(4'd0, 4'd0, 1'b1);
        tick();
        bus.wbValid = 1'b0;
        bus.rdAddrB = 4'd15;
        #1;
        check("ovf_rd", bus.rdDataB, 32'hDEAD);
        check("ovf_pc", 32'(bus.pc), 32'h8);

        // LOAD with data in the same cycle: no stall
        issue(5'h01, 4'd6, 3'd0, 1'b0, 32'h0, 8'h00);
        bus.dataValid = 1'b1;
        bus.dataIn    = 32'hBEEF;
        #1;
        check("ldq_stall", 32'(bus.stall), 32'h0);
        tick();
        bus.wbValid   = 1'b0;
        bus.dataValid = 1'b0;
        check("ldq_cpustatus", 32'(bus.cpuStatus), 32'h01);
        check("ldq_pc", 32'(bus.pc), 32'h9);
        bus.rdAddrA = 4'd6;
        #1;
        check("ldq_r6", bus.rdDataA, 32'hBEEF);

        // PC write 0x12A5 -> pc 0x2A5, flush for exactly three cycles
        issue(5'h03, 4'd14, 3'd1, 1'b0, 32'h12A5, 8'h00);
        #1;
        check("pcw_noflush", 32'(bus.flushRst), 32'h0);
        tick();
        check("pcw_flush1", 32'(bus.flushRst), 32'h1);
        check("pcw_pc", 32'(bus.pc), 32'h2A5);
        issue(5'h01, 4'd5, 3'd0, 1'b0, 32'h0, 8'h00);
        bus.dataValid = 1'b0;
        #1;
        check("pcw_flush_beats_stall", 32'(bus.stall), 32'h0);
        tick();
        check("pcw_flush2", 32'(bus.flushRst), 32'h1);
        issue(5'h03, 4'd3, 3'd1, 1'b0, 32'h9999, 8'h00);
        tick();
        check("pcw_flush3", 32'(bus.flushRst), 32'h1);
        check("pcw_pc_hold", 32'(bus.pc), 32'h2A5);
        bus.wbValid = 1'b0;
        tick();
        check("pcw_flush_end", 32'(bus.flushRst), 32'h0);
        check("pcw_pc_after", 32'(bus.pc), 32'h2A5);
        bus.rdAddrA = 4'd3;
        #1;
        check("pcw_ignored", bus.rdDataA, 32'h1234);

        // HALT: stall stuck, pc frozen, later instructions ignored
        issue(5'h1F, 4'd0, 3'd0, 1'b0, 32'h0, 8'h00);
        tick();
        issue(5'h03, 4'd3, 3'd1, 1'b0, 32'hAAAA, 8'h00);
        check("halt_stall", 32'(bus.stall), 32'h1);
        check("halt_cpustatus", 32'(bus.cpuStatus), 32'h04);
        check("halt_pc", 32'(bus.pc), 32'h2A5);
        tick();
        tick();
        check("halt_stall_stuck", 32'(bus.stall), 32'h1);
        check("halt_pc_frozen", 32'(bus.pc), 32'h2A5);
        check("halt_r3", bus.rdDataA, 32'h1234);

        // Asynchronous reset mid-HALT
        #2 nRst = 1'b0;
        #1;
        check("arst_pc", 32'(bus.pc), 32'h0);
        check("arst_cpustatus", 32'(bus.cpuStatus), 32'h02);
        check("arst_stall", 32'(bus.stall), 32'h0);
        check("arst_flush", 32'(bus.flushRst), 32'h1);
        check("arst_r3", bus.rdDataA, 32'h0);
        check("arst_status", 32'(bus.status), 32'h0);
        check("arst_fwdData", bus.fwdData, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_ctrl.md
# writeback_ctrl

Parametrised writeback, register-file and pipeline-control stage for the coffee-cpu core. It retires the instruction leaving Execute and evaluates its write condition, including new GT/LE codes. It commits the result to a general register, PC or overflow, and forwards it to both Execute operands. It adds what the previous core lacked: a load-data handshake with stall, a configurable flush length, a HALT opcode, and two register-file read ports for Decode.

## Interface
- DATA_W, 32, datapath width
- PC_W, 12, program-counter width
- REG_AW, 4, register-address width; index 2^REG_AW-2 = PC, 2^REG_AW-1 = overflow, lower indices = general registers
- FLUSH_CYCLES, 1, cycles flushRst is held after a PC write (1..15)

Ports:
- clk  in  1  clock
- nRst  in  1  reset; one clock, asynchronous, active-low
- wbValid  in  1  instruction at writeback is valid
- wbOpc  in  5  opcode (0 NOP, 1 LOAD, 5'h1F HALT)
- wbRc  in  REG_AW  destination
- wbCond  in  3  write condition
- wbCmp  in  1  update status flags
- aluOut  in  DATA_W  ALU result
- aluStatus  in  8  ALU flags ([0] zero, [2] ge)
- dataIn  in  DATA_W  load data
- dataValid  in  1  load data valid this cycle
- exRa, exRb  in  REG_AW  operands of the instruction in Execute
- exImb  in  1  Execute B operand is immediate
- rdAddrA, rdAddrB  in  REG_AW  Decode read addresses
- rdDataA, rdDataB  out  DATA_W  combinational read data (PC zero-extended, overflow)
- pc  out  PC_W  program counter
- stall  out  1  hold Fetch/Decode/Execute (combinational)
- flushRst  out  1  synchronous pipeline reset
- fwdData  out  DATA_W  forwarded value
- fwdEnA, fwdEnB  out  1  override Execute A / B operand
- status  out  8  committed flags
- cpuStatus  out  8  0x02 reset, 0x01 run, 0x08 load wait, 0x04 halted

## Operation
- States: RUN, LOADWAIT, FLUSH, HALT.
- Conditions: 0 NEVER, 1 ALWAYS, 2 ZERO, 3 NOTZERO, 4 GE, 5 LT, 6 GT (ge&!zero), 7 LE (!ge|zero). All evaluated against `status`.
- Retire: in RUN/LOADWAIT with wbValid and stall low.
- Commit:
  - LOAD commits dataIn unconditionally.
  - Other non-NOP, non-HALT opcodes commit aluOut when the condition is true.
  - NOP and a false condition only advance pc.
- Targets:
  - General index writes r[wbRc].
  - PC index: pc <= value[PC_W-1:0]; go to FLUSH.
  - Overflow index writes `overflow`.
- pc increments by 1 on every retire except a PC write or HALT.
- Status: `status <= aluStatus` on a retired non-LOAD with wbCmp=1.
- LOAD with dataValid low:
  - stall=1; enter/stay LOADWAIT.
  - Commit in the first cycle dataValid=1; RUN next, or FLUSH if Rc=PC.
- Forwarding, registered on commit to a non-PC target:
  - fwdData <= value.
  - fwdEnA <= (exRa==wbRc); fwdEnB <= (!exImb && exRb==wbRc). Both may be 1.
  - Cleared on a retire without commit. Held while stall=1.
- FLUSH: flushRst=1 for FLUSH_CYCLES cycles via a down-counter, then RUN. Instructions presented meanwhile are ignored.
- HALT retire: enter HALT, stall=1 permanently. pc frozen. Exit only by reset.

## Timing
- Reset (async):
  - Registers, pc, overflow, status, fwd*, and flush counter cleared to 0.
  - State RUN; cpuStatus 0x02.
  - flushRst=1 for the first cycle after release, then cpuStatus 0x01.
- Register and pc writes are visible on rdData the cycle after commit. No internal bypass on read ports; Execute forwarding covers it.
- fwdEn* are valid one cycle after the producing commit.
- PC write: flushRst high from the next cycle for exactly FLUSH_CYCLES cycles. pc holds the target throughout.
- dataValid in the same cycle as the LOAD arriving: no stall, no LOADWAIT.
- Simultaneous flush and stall: flush wins and stall drops.
- Reset during LOADWAIT, FLUSH or HALT aborts immediately to the reset values.

## Structure
- Shared package `cpu_pkg`: opcode constants (NOP, LOAD, STORE…HALT), condition codes, state enum, cpuStatus codes, PC/overflow index functions of REG_AW.
- Sub-module `wb_cond_eval`: combinational cond+flags → enable, reused by future branch prediction.

## Test plan
- Reset release: pc=0, all rdData=0, cpuStatus 0x02→0x01, flushRst one cycle.
- ADD Rc=3, ALWAYS, aluOut=0x1234, exRa=3, exRb=3, exImb=0 → r3=0x1234; fwdEnA=fwdEnB=1, fwdData=0x1234; pc 0→1.
- wbCmp with aluStatus=0x04, then GT cond Rc=2 → commits. Same with status zero=1 → no commit, pc still +1.
- LOAD Rc=5, dataValid low 3 cycles then dataIn=0xCAFE → stall 3 cycles, cpuStatus 0x08, r5=0xCAFE, pc+1 once.
- FLUSH_CYCLES=3, write Rc=PC value 0x2A5 → pc=0x2A5, flushRst high exactly 3 cycles.
- HALT retire → stall stuck 1, cpuStatus 0x04, pc frozen. nRst low mid-HALT → all reset values asynchronously.
